exc_ctrl: RTL

- Precise-exception controller at the MEM/commit boundary of the 5-stage pipeline.
- Each cycle it takes the committing instruction's exception flags and the CP0 Status/Cause/EPC values, and decides whether an exception or ERET is taken, choosing one cause by fixed priority.
- It then sequences the CP0 update, the pipeline flush and the fetch redirect through a small FSM.
- It drives the existing CP0 excepttype_i / pc_i / bad_vaddr_i / is_in_delayslot_i inputs.

---
 rtl/exc_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/exc_ctrl.sv
// Precise-exception controller at the MEM/commit boundary: picks one cause by fixed
// priority, then sequences the CP0 update pulse, the pipeline flush and the fetch redirect.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int          CODE_W     = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_valid_i,
  input  logic [31:0]       pc_i,
  input  logic              in_delayslot_i,
  input  logic [31:0]       data_addr_i,
  input  logic [8:0]        exc_flags_i,
  input  logic [31:0]       status_i,
  input  logic [31:0]       cause_i,
  input  logic [31:0]       epc_i,
  output logic [CODE_W-1:0] excepttype_o,
  output logic [31:0]       exc_pc_o,
  output logic [31:0]       exc_badvaddr_o,
  output logic              exc_delayslot_o,
  output logic              flush_o,
  output logic              busy_o,
  output logic              redirect_valid_o,
  output logic [31:0]       redirect_pc_o,
  input  logic              redirect_ready_i,
  output logic [31:0]       exc_count_o
);

  typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT} state_e;

  state_e      state_q;
  logic [31:0] target_q;

  logic              int_pend;
  logic              take;
  logic [CODE_W-1:0] code_d;
  logic [31:0]       badvaddr_d;
  logic [31:0]       target_d;
  logic              is_eret;

  // Interrupts need IE set, EXL clear and at least one unmasked pending line.
  assign int_pend = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));
  assign take     = inst_valid_i & (int_pend | (|exc_flags_i));

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    code_d     = '0;
    badvaddr_d = '0;
    is_eret    = 1'b0;
    if (int_pend)            code_d = CODE_W'(32'h1);
    else if (exc_flags_i[8]) begin
      code_d     = CODE_W'(32'h4);
      badvaddr_d = pc_i;
    end
    else if (exc_flags_i[7]) code_d = CODE_W'(32'hA);
    else if (exc_flags_i[6]) code_d = CODE_W'(32'h8);
    else if (exc_flags_i[5]) code_d = CODE_W'(32'h9);
    else if (exc_flags_i[4]) code_d = CODE_W'(32'hC);
    else if (exc_flags_i[3]) code_d = CODE_W'(32'hD);
    else if (exc_flags_i[2]) begin
      code_d     = CODE_W'(32'h4);
      badvaddr_d = data_addr_i;
    end
    else if (exc_flags_i[1]) begin
      code_d     = CODE_W'(32'h5);
      badvaddr_d = data_addr_i;
    end
    else if (exc_flags_i[0]) begin
      code_d  = CODE_W'(32'hE);
      is_eret = 1'b1;
    end
    target_d = is_eret ? epc_i : EXC_VECTOR;
  end

  // NOTE: all state here is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= IDLE;
      target_q         <= '0;
      excepttype_o     <= '0;
      exc_pc_o         <= '0;
      exc_badvaddr_o   <= '0;
      exc_delayslot_o  <= 1'b0;
      flush_o          <= 1'b0;
      busy_o           <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
      exc_count_o      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take) begin
            excepttype_o    <= code_d;
            exc_pc_o        <= pc_i;
            exc_badvaddr_o  <= badvaddr_d;
            exc_delayslot_o <= in_delayslot_i;
            target_q        <= target_d;
            flush_o         <= 1'b1;
            busy_o          <= 1'b1;
            exc_count_o     <= exc_count_o + 32'd1;
            state_q         <= COMMIT;
          end
        end
        COMMIT: begin
          // The CP0 pulse lasts exactly this one cycle.
          excepttype_o     <= '0;
          redirect_valid_o <= 1'b1;
          redirect_pc_o    <= target_q;
          state_q          <= REDIRECT;
        end
        REDIRECT: begin
          if (redirect_ready_i) begin
            redirect_valid_o <= 1'b0;
            flush_o          <= 1'b0;
            busy_o           <= 1'b0;
            state_q          <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
